// File: rtl/seven_segment_reader.sv
// seven_segment_reader
// Recovers the hex word shown on a multiplexed, active-low 7-segment bus.
// A digit is accepted once its {an, seg} sample has been seen on
// STABLE_CYCLES consecutive edges. When every digit has been captured, the
// frame is published on value with a one-cycle value_valid strobe.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   seg[6:0]     active-low segments (0 top, 1 UR, 2 LR, 3 bottom, 4 LL, 5 UL, 6 middle)
//   an[DIGITS]   active-low digit enables; exactly one low selects a digit
//   value        last complete frame; digit i at value[4i+3:4i]
//   value_valid  one-cycle pulse when value updates
//   frame_err    1 if any digit of the published frame held an illegal code
module seven_segment_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic                  frame_err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned VW = 4 * DIGITS;

  // Segment pattern to {legal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Registered state
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic [CW-1:0]     cnt;
  logic [VW-1:0]     nib;
  logic [DIGITS-1:0] captured;
  logic [DIGITS-1:0] err;

  // Combinational next-state
  logic [3:0]        zero_cnt_c;
  logic              selectable_c;
  logic              same_c;
  logic              capture_c;
  logic              all_cap_c;
  logic [4:0]        dec_c;
  logic [CW-1:0]     cnt_nxt_c;
  logic [VW-1:0]     nib_nxt_c;
  logic [DIGITS-1:0] cap_nxt_c;
  logic [DIGITS-1:0] err_nxt_c;

  // Number of asserted (low) digit enables; exactly one means selectable.
  always_comb begin
    zero_cnt_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!an[i]) zero_cnt_c = zero_cnt_c + 4'd1;
    end
  end

  assign selectable_c = (zero_cnt_c == 4'd1);
  assign same_c       = ({an, seg} == {an_q, seg_q});
  assign all_cap_c    = &captured;
  assign dec_c        = decode(seg);

  // Capture fires only on the STABLE_CYCLES-1 -> STABLE_CYCLES step, so a
  // saturated counter never recaptures the same dwell.
  assign capture_c = selectable_c && same_c && (cnt == CW'(STABLE_CYCLES - 1));

  // Dwell counter: extend on a repeated selectable sample, otherwise restart.
  always_comb begin
    cnt_nxt_c = '0;
    if (selectable_c && same_c) begin
      cnt_nxt_c = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
    end else if (selectable_c) begin
      cnt_nxt_c = CW'(1);
    end
  end

  // Frame bookkeeping. Completion clears captured/err first so a capture on
  // the completion edge lands in the following frame.
  always_comb begin
    nib_nxt_c = nib;
    cap_nxt_c = all_cap_c ? '0 : captured;
    err_nxt_c = all_cap_c ? '0 : err;
    if (capture_c) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (!an[i]) begin
          cap_nxt_c[i]         = 1'b1;
          err_nxt_c[i]         = ~dec_c[4];
          nib_nxt_c[4*i +: 4]  = dec_c[3:0];
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= '1;
      seg_q       <= '1;
      cnt         <= '0;
      nib         <= '0;
      captured    <= '0;
      err         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      an_q        <= an;
      seg_q       <= seg;
      cnt         <= cnt_nxt_c;
      nib         <= nib_nxt_c;
      captured    <= cap_nxt_c;
      err         <= err_nxt_c;
      value_valid <= all_cap_c;
      if (all_cap_c) begin
        value     <= nib;
        frame_err <= |err;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with a published-frame scoreboard.
module tb_seven_segment_reader;

  localparam logic [6:0] SEGTAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef struct packed {
    logic [15:0] v;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '1;
  logic [3:0]  an  = '1;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_err;

  int   tests  = 0;
  int   failed = 0;
  int   pulses = 0;
  int   cyc    = 0;
  int   start_cyc = 0;
  int   valid_cyc = -1;
  logic prev_v = 1'b0;
  exp_t q[$];

  seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .value(value), .value_valid(value_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raw drive for n edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      an = a; seg = s;
    end
  endtask

  // Show one digit for n edges, then a blanking gap.
  task automatic show(input int d, input logic [6:0] s, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) start_cyc = cyc;
      an = ~(4'(1) << d); seg = s;
    end
    drive(4'b1111, SEG_OFF, gap);
  endtask

  // Monitor: every published frame must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (value_valid) begin
        pulses++;
        valid_cyc = cyc;
        chk("valid_spacing", 32'(prev_v), 32'd0);
        if (q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_publish: got value %0h err %0b expected no pulse (t=%0t)",
                   value, frame_err, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_value", 32'(value), 32'(e.v));
          chk("frame_err", 32'(frame_err), 32'(e.e));
        end
      end
      prev_v = value_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    // Reset held 3 cycles with arbitrary inputs
    an = 4'($urandom); seg = 7'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_valid", 32'(value_valid), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      an = 4'($urandom); seg = 7'($urandom);
    end
    rst = 1'b0; an = '1; seg = SEG_OFF;
    @(negedge clk);
    chk("post_rst_value", 32'(value), 32'd0);
    chk("post_rst_valid", 32'(value_valid), 32'd0);
    chk("post_rst_ferr", 32'(frame_err), 32'd0);

    // Normal frame: F,2,A,1 on digits 0..3
    q.push_back('{16'h1A2F, 1'b0});
    show(0, SEGTAB[15], 8, 2);
    show(1, SEGTAB[2], 8, 2);
    show(2, SEGTAB[10], 8, 2);
    show(3, SEGTAB[1], 8, 2);
    chk("publish_latency", 32'(valid_cyc - start_cyc), 32'd5);

    // Short dwell on digit 2 blocks the frame
    show(0, SEGTAB[9], 8, 2);
    show(1, SEGTAB[9], 8, 2);
    show(3, SEGTAB[9], 8, 2);
    show(2, SEGTAB[9], 3, 2);
    drive(4'b1111, SEG_OFF, 6);
    chk("short_dwell_hold", 32'(value), 32'h1A2F);
    // Next scan overwrites earlier captures; digit 2 at the minimum dwell
    q.push_back('{16'h7654, 1'b0});
    show(0, SEGTAB[4], 8, 2);
    show(1, SEGTAB[5], 8, 2);
    show(3, SEGTAB[7], 8, 2);
    show(2, SEGTAB[6], 4, 3);

    // Illegal code on digit 1, then a clean frame
    q.push_back('{16'h3303, 1'b1});
    show(0, SEGTAB[3], 6, 1);
    show(1, SEG_OFF, 6, 1);
    show(2, SEGTAB[3], 6, 1);
    show(3, SEGTAB[3], 6, 3);
    q.push_back('{16'h3210, 1'b0});
    show(0, SEGTAB[0], 5, 2);
    show(1, SEGTAB[1], 5, 2);
    show(2, SEGTAB[2], 5, 2);
    show(3, SEGTAB[3], 5, 3);

    // Conflict never captures; digit 0 recaptured 5 then 7
    drive(4'b1100, SEGTAB[8], 10);
    drive(4'b1111, SEG_OFF, 2);
    q.push_back('{16'h0007, 1'b0});
    show(0, SEGTAB[5], 8, 0);
    show(0, SEGTAB[7], 8, 2);
    show(1, SEGTAB[0], 6, 1);
    show(2, SEGTAB[0], 6, 1);
    show(3, SEGTAB[0], 6, 3);
    chk("held_value", 32'(value), 32'h0007);

    // Reset mid-frame discards digits 0 and 1
    show(0, SEGTAB[10], 6, 1);
    show(1, SEGTAB[11], 6, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_value", 32'(value), 32'd0);
    chk("midrst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    show(2, SEGTAB[12], 6, 1);
    show(3, SEGTAB[13], 6, 4);
    chk("partial_no_publish", 32'(value), 32'd0);
    q.push_back('{16'hDCBA, 1'b0});
    show(2, SEGTAB[12], 6, 1);
    show(3, SEGTAB[13], 6, 1);
    show(0, SEGTAB[10], 6, 1);
    show(1, SEGTAB[11], 6, 10);

    chk("pending_expect", 32'(q.size()), 32'd0);
    chk("pulse_count", 32'(pulses), 32'd6);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
